// File: rtl/vending_pkg.sv
// Shared definitions for the multi-item vending machine: state encodings and coin decode.
package vending_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CREDIT   = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_CHANGE   = 3'd3,
    ST_COMPLETE = 3'd4
  } state_e;

  localparam logic [1:0] COIN_1   = 2'b00;
  localparam logic [1:0] COIN_2   = 2'b01;
  localparam logic [1:0] COIN_5   = 2'b10;
  localparam logic [1:0] COIN_BAD = 2'b11;

  localparam int unsigned COIN_AMT_W = 3;

  // Credit units carried by a coin code; the invalid code is worth nothing.
  function automatic logic [COIN_AMT_W-1:0] coin_amount(input logic [1:0] code);
    logic [COIN_AMT_W-1:0] amt;
    case (code)
      COIN_1:  amt = 3'd1;
      COIN_2:  amt = 3'd2;
      COIN_5:  amt = 3'd5;
      default: amt = 3'd0;
    endcase
    return amt;
  endfunction

endpackage

// File: rtl/vm_stock_bank.sv
// Per-item stock counters with single-item decrement and bulk restock.
module vm_stock_bank #(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 restock,
  input  logic                 dec,
  input  logic [SEL_W-1:0]     dec_idx,
  output logic [NUM_ITEMS-1:0] empty_c
);

  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      stock_d[i] = stock_q[i];
      empty_c[i] = (stock_q[i] == '0);
      if (restock) begin
        stock_d[i] = STOCK_W'(STOCK_INIT);
      end else if (dec && (dec_idx == SEL_W'(i)) && (stock_q[i] != '0)) begin
        stock_d[i] = stock_q[i] - STOCK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) stock_q[i] <= stock_d[i];
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: credit accumulation, vend with timed dispense,
// unit-by-unit change refund, and per-item stock tracking.
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int unsigned NUM_ITEMS       = 4,
  parameter int unsigned SEL_W           = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
  parameter int unsigned PRICE           = 3,
  parameter int unsigned CREDIT_W        = 4,
  parameter int unsigned DISPENSE_CYCLES = 5,
  parameter int unsigned STOCK_W         = 4,
  parameter int unsigned STOCK_INIT      = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 coin,
  input  logic [1:0]           coin_value,
  input  logic [SEL_W-1:0]     select,
  input  logic                 dispense,
  input  logic                 cancel,
  input  logic                 restock,
  output logic [NUM_ITEMS-1:0] vend_out,
  output logic                 change_out,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 coin_reject,
  output logic                 vend_err,
  output logic [2:0]           status
);

  localparam int unsigned SUM_W = ((CREDIT_W > COIN_AMT_W) ? CREDIT_W : COIN_AMT_W) + 1;
  localparam int unsigned CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [SUM_W-1:0] MAX_CREDIT = SUM_W'((2 ** CREDIT_W) - 1);

  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_ITEMS-1:0] vend_out_q, vend_out_d;
  logic                 change_out_q, change_out_d;
  logic                 coin_reject_q, coin_reject_d;
  logic                 vend_err_q, vend_err_d;

  logic [NUM_ITEMS-1:0] empty_c;
  logic [SUM_W-1:0]     coin_sum;
  logic                 coin_fits, coin_acc, coin_rej, vend_ok, vend_bad, item_avail;

  vm_stock_bank #(
    .NUM_ITEMS (NUM_ITEMS),
    .SEL_W     (SEL_W),
    .STOCK_W   (STOCK_W),
    .STOCK_INIT(STOCK_INIT)
  ) u_stock (
    .clk    (clk),
    .reset_n(reset_n),
    .restock((state_q == ST_IDLE) && restock),
    .dec    (vend_ok),
    .dec_idx(select),
    .empty_c(empty_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      cnt_q         <= '0;
      sel_q         <= '0;
      vend_out_q    <= '0;
      change_out_q  <= 1'b0;
      coin_reject_q <= 1'b0;
      vend_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      vend_out_q    <= vend_out_d;
      change_out_q  <= change_out_d;
      coin_reject_q <= coin_reject_d;
      vend_err_q    <= vend_err_d;
    end
  end

  // Next state and credit/counter datapath; priority in CREDIT is cancel > dispense > coin.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    coin_acc   = 1'b0;
    coin_rej   = 1'b0;
    vend_ok    = 1'b0;
    vend_bad   = 1'b0;
    coin_sum   = SUM_W'(credit_q) + SUM_W'(coin_amount(coin_value));
    coin_fits  = (coin_value != COIN_BAD) && (coin_sum <= MAX_CREDIT);
    item_avail = (32'(select) < NUM_ITEMS) && !empty_c[select];

    case (state_q)
      ST_IDLE: begin
        coin_acc = coin && coin_fits;
        coin_rej = coin && !coin_fits;
      end
      ST_CREDIT: begin
        if (cancel) begin
          state_d  = ST_CHANGE;
          coin_rej = coin;
        end else if (dispense) begin
          coin_rej = coin;
          vend_ok  = item_avail && (credit_q >= CREDIT_W'(PRICE));
          vend_bad = !vend_ok;
        end else begin
          coin_acc = coin && coin_fits;
          coin_rej = coin && !coin_fits;
        end
      end
      ST_DISPENSE: begin
        coin_rej = coin;
        if (cnt_q == CNT_W'(DISPENSE_CYCLES - 1)) state_d = ST_CHANGE;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      ST_CHANGE: begin
        coin_rej = coin;
        if (credit_q == '0) state_d = ST_COMPLETE;
        else credit_d = credit_q - CREDIT_W'(1);
      end
      ST_COMPLETE: begin
        coin_rej = coin;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (coin_acc) begin
      credit_d = CREDIT_W'(coin_sum);
      state_d  = ST_CREDIT;
    end
    if (vend_ok) begin
      credit_d = credit_q - CREDIT_W'(PRICE);
      sel_d    = select;
      cnt_d    = '0;
      state_d  = ST_DISPENSE;
    end
  end

  // Registered outputs are computed from the next state so they line up with status.
  always_comb begin
    vend_out_d    = '0;
    change_out_d  = 1'b0;
    coin_reject_d = coin_rej;
    vend_err_d    = vend_bad;
    if (state_d == ST_DISPENSE) vend_out_d = NUM_ITEMS'(1) << sel_d;
    if ((state_d == ST_CHANGE) && (credit_d != '0)) change_out_d = 1'b1;
  end

  assign vend_out    = vend_out_q;
  assign change_out  = change_out_q;
  assign credit      = credit_q;
  assign sold_out    = empty_c;
  assign coin_reject = coin_reject_q;
  assign vend_err    = vend_err_q;
  assign status      = state_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Self-checking bench for vending_machine_multi at default parameters.
module tb_vending_machine_multi;
  import vending_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       coin;
  logic [1:0] coin_value;
  logic [1:0] select;
  logic       dispense;
  logic       cancel;
  logic       restock;
  logic [3:0] vend_out;
  logic       change_out;
  logic [3:0] credit;
  logic [3:0] sold_out;
  logic       coin_reject;
  logic       vend_err;
  logic [2:0] status;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      name;
    logic       coin;
    logic [1:0] cv;
    logic [1:0] sel;
    logic       disp, cncl, rstk;
    logic [3:0] vend;
    logic       chg;
    logic [3:0] cr;
    logic [3:0] sold;
    logic       rej, err;
    logic [2:0] st;
  } vec_t;

  typedef struct {
    string       name;
    logic [17:0] bits;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[$];

  vending_machine_multi dut (
    .clk(clk), .reset_n(reset_n), .coin(coin), .coin_value(coin_value),
    .select(select), .dispense(dispense), .cancel(cancel), .restock(restock),
    .vend_out(vend_out), .change_out(change_out), .credit(credit),
    .sold_out(sold_out), .coin_reject(coin_reject), .vend_err(vend_err),
    .status(status)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic vec_t mk(string n, logic c, logic [1:0] cv, logic [1:0] s, logic d,
                              logic cn, logic rs, logic [3:0] vo, logic ch, logic [3:0] cr,
                              logic [3:0] so, logic rj, logic er, logic [2:0] st);
    vec_t v;
    v.name = n; v.coin = c; v.cv = cv; v.sel = s; v.disp = d; v.cncl = cn; v.rstk = rs;
    v.vend = vo; v.chg = ch; v.cr = cr; v.sold = so; v.rej = rj; v.err = er; v.st = st;
    return v;
  endfunction

  function automatic vec_t idl(string n, logic [3:0] vo, logic ch, logic [3:0] cr,
                               logic [3:0] so, logic rj, logic er, logic [2:0] st);
    return mk(n, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, vo, ch, cr, so, rj, er, st);
  endfunction

  task automatic check_next();
    exp_t        e;
    logic [17:0] act;
    e   = sb_q.pop_front();
    act = {vend_out, change_out, credit, sold_out, coin_reject, vend_err, status};
    n_checks++;
    if (act !== e.bits) begin
      n_errors++;
      $display("FAIL %s: got vend=%b chg=%b credit=%0d sold=%b rej=%b err=%b st=%0d; want vend=%b chg=%b credit=%0d sold=%b rej=%b err=%b st=%0d",
               e.name, act[17:14], act[13], act[12:9], act[8:5], act[4], act[3], act[2:0],
               e.bits[17:14], e.bits[13], e.bits[12:9], e.bits[8:5], e.bits[4], e.bits[3], e.bits[2:0]);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    coin = v.coin; coin_value = v.cv; select = v.sel;
    dispense = v.disp; cancel = v.cncl; restock = v.rstk;
    e.name = v.name;
    e.bits = {v.vend, v.chg, v.cr, v.sold, v.rej, v.err, v.st};
    sb_q.push_back(e);
    @(posedge clk); #1;
    check_next();
  endtask

  task automatic expect_now(input string n, input logic [17:0] bits);
    exp_t e;
    e.name = n; e.bits = bits;
    sb_q.push_back(e);
    check_next();
  endtask

  task automatic chk_stock(input string n, input logic [3:0] act, input logic [3:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got stock=%0d want stock=%0d", n, act, want);
    end
  endtask

  // Exact-credit vend (2 + 1) of one item with no change due.
  task automatic do_vend(input string n, input logic [1:0] s, input logic [3:0] so_pre,
                         input logic [3:0] so_post);
    logic [3:0] oh;
    oh = 4'b0001 << s;
    apply(mk({n, "_c2"}, 1, COIN_2, 0, 0, 0, 0, 4'b0, 0, 4'd2, so_pre, 0, 0, 3'd1));
    apply(mk({n, "_c1"}, 1, COIN_1, 0, 0, 0, 0, 4'b0, 0, 4'd3, so_pre, 0, 0, 3'd1));
    apply(mk({n, "_disp"}, 0, 0, s, 1, 0, 0, oh, 0, 4'd0, so_post, 0, 0, 3'd2));
    for (int k = 0; k < 4; k++) apply(idl({n, "_hold"}, oh, 0, 4'd0, so_post, 0, 0, 3'd2));
    apply(idl({n, "_chg"}, 4'b0, 0, 4'd0, so_post, 0, 0, 3'd3));
    apply(idl({n, "_cmp"}, 4'b0, 0, 4'd0, so_post, 0, 0, 3'd4));
    apply(idl({n, "_idle"}, 4'b0, 0, 4'd0, so_post, 0, 0, 3'd0));
  endtask

  initial begin
    reset_n = 1'b0; coin = 0; coin_value = 0; select = 0;
    dispense = 0; cancel = 0; restock = 0;
    #12;
    expect_now("reset_state", 18'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Coins 2+1, vend item 1, no change.
    tbl.push_back(mk("a_coin2", 1, COIN_2, 0, 0, 0, 0, 4'b0000, 0, 4'd2, 4'b0, 0, 0, 3'd1));
    tbl.push_back(mk("a_coin1", 1, COIN_1, 0, 0, 0, 0, 4'b0000, 0, 4'd3, 4'b0, 0, 0, 3'd1));
    tbl.push_back(mk("a_disp",  0, 0, 2'd1, 1, 0, 0, 4'b0010, 0, 4'd0, 4'b0, 0, 0, 3'd2));
    for (int k = 0; k < 4; k++) tbl.push_back(idl("a_hold", 4'b0010, 0, 4'd0, 4'b0, 0, 0, 3'd2));
    tbl.push_back(idl("a_change",   4'b0, 0, 4'd0, 4'b0, 0, 0, 3'd3));
    tbl.push_back(idl("a_complete", 4'b0, 0, 4'd0, 4'b0, 0, 0, 3'd4));
    tbl.push_back(idl("a_idle",     4'b0, 0, 4'd0, 4'b0, 0, 0, 3'd0));
    // Coin 5, vend item 0, two change pulses.
    tbl.push_back(mk("b_coin5", 1, COIN_5, 0, 0, 0, 0, 4'b0000, 0, 4'd5, 4'b0, 0, 0, 3'd1));
    tbl.push_back(mk("b_disp",  0, 0, 2'd0, 1, 0, 0, 4'b0001, 0, 4'd2, 4'b0, 0, 0, 3'd2));
    for (int k = 0; k < 4; k++) tbl.push_back(idl("b_hold", 4'b0001, 0, 4'd2, 4'b0, 0, 0, 3'd2));
    tbl.push_back(idl("b_chg2",     4'b0, 1, 4'd2, 4'b0, 0, 0, 3'd3));
    tbl.push_back(idl("b_chg1",     4'b0, 1, 4'd1, 4'b0, 0, 0, 3'd3));
    tbl.push_back(idl("b_chg0",     4'b0, 0, 4'd0, 4'b0, 0, 0, 3'd3));
    tbl.push_back(idl("b_complete", 4'b0, 0, 4'd0, 4'b0, 0, 0, 3'd4));
    tbl.push_back(idl("b_idle",     4'b0, 0, 4'd0, 4'b0, 0, 0, 3'd0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    chk_stock("stock1_after_vend", dut.u_stock.stock_q[1], 4'd1);
    chk_stock("stock0_after_vend", dut.u_stock.stock_q[0], 4'd1);

    // Sell out item 2, then a refused vend, cancel refund, restock.
    do_vend("c_v1", 2'd2, 4'b0000, 4'b0000);
    do_vend("c_v2", 2'd2, 4'b0000, 4'b0100);
    apply(mk("c_coin2", 1, COIN_2, 0, 0, 0, 0, 4'b0, 0, 4'd2, 4'b0100, 0, 0, 3'd1));
    apply(mk("c_coin1", 1, COIN_1, 0, 0, 0, 0, 4'b0, 0, 4'd3, 4'b0100, 0, 0, 3'd1));
    apply(mk("c_soldout_err", 0, 0, 2'd2, 1, 0, 0, 4'b0, 0, 4'd3, 4'b0100, 0, 1, 3'd1));
    apply(mk("c_cancel", 0, 0, 0, 0, 1, 0, 4'b0, 1, 4'd3, 4'b0100, 0, 0, 3'd3));
    apply(idl("c_chg2", 4'b0, 1, 4'd2, 4'b0100, 0, 0, 3'd3));
    apply(idl("c_chg1", 4'b0, 1, 4'd1, 4'b0100, 0, 0, 3'd3));
    apply(idl("c_chg0", 4'b0, 0, 4'd0, 4'b0100, 0, 0, 3'd3));
    apply(idl("c_complete", 4'b0, 0, 4'd0, 4'b0100, 0, 0, 3'd4));
    apply(idl("c_idle", 4'b0, 0, 4'd0, 4'b0100, 0, 0, 3'd0));
    apply(mk("c_restock", 0, 0, 0, 0, 0, 1, 4'b0, 0, 4'd0, 4'b0000, 0, 0, 3'd0));
    chk_stock("stock2_after_restock", dut.u_stock.stock_q[2], 4'd2);

    // Invalid coin in IDLE, credit overflow and invalid coin in CREDIT.
    apply(mk("d_bad_idle", 1, COIN_BAD, 0, 0, 0, 0, 4'b0, 0, 4'd0, 4'b0, 1, 0, 3'd0));
    apply(mk("d_c5a", 1, COIN_5, 0, 0, 0, 0, 4'b0, 0, 4'd5,  4'b0, 0, 0, 3'd1));
    apply(mk("d_c5b", 1, COIN_5, 0, 0, 0, 0, 4'b0, 0, 4'd10, 4'b0, 0, 0, 3'd1));
    apply(mk("d_c2a", 1, COIN_2, 0, 0, 0, 0, 4'b0, 0, 4'd12, 4'b0, 0, 0, 3'd1));
    apply(mk("d_c2b", 1, COIN_2, 0, 0, 0, 0, 4'b0, 0, 4'd14, 4'b0, 0, 0, 3'd1));
    apply(mk("d_overflow", 1, COIN_5, 0, 0, 0, 0, 4'b0, 0, 4'd14, 4'b0, 1, 0, 3'd1));
    apply(mk("d_bad_code", 1, COIN_BAD, 0, 0, 0, 0, 4'b0, 0, 4'd14, 4'b0, 1, 0, 3'd1));
    apply(idl("d_rej_clear", 4'b0, 0, 4'd14, 4'b0, 0, 0, 3'd1));
    apply(mk("d_cancel", 0, 0, 0, 0, 1, 0, 4'b0, 1, 4'd14, 4'b0, 0, 0, 3'd3));
    for (int k = 13; k >= 0; k--)
      apply(idl($sformatf("d_chg%0d", k), 4'b0, (k > 0), 4'(k), 4'b0, 0, 0, 3'd3));
    apply(idl("d_complete", 4'b0, 0, 4'd0, 4'b0, 0, 0, 3'd4));
    apply(idl("d_idle", 4'b0, 0, 4'd0, 4'b0, 0, 0, 3'd0));

    // Cancel beats dispense; coin during DISPENSE is rejected.
    apply(mk("e_coin2", 1, COIN_2, 0, 0, 0, 0, 4'b0, 0, 4'd2, 4'b0, 0, 0, 3'd1));
    apply(mk("e_coin1", 1, COIN_1, 0, 0, 0, 0, 4'b0, 0, 4'd3, 4'b0, 0, 0, 3'd1));
    apply(mk("e_cancel_disp", 0, 0, 2'd1, 1, 1, 0, 4'b0, 1, 4'd3, 4'b0, 0, 0, 3'd3));
    apply(idl("e_chg2", 4'b0, 1, 4'd2, 4'b0, 0, 0, 3'd3));
    apply(idl("e_chg1", 4'b0, 1, 4'd1, 4'b0, 0, 0, 3'd3));
    apply(idl("e_chg0", 4'b0, 0, 4'd0, 4'b0, 0, 0, 3'd3));
    apply(idl("e_complete", 4'b0, 0, 4'd0, 4'b0, 0, 0, 3'd4));
    apply(idl("e_idle", 4'b0, 0, 4'd0, 4'b0, 0, 0, 3'd0));
    chk_stock("stock1_no_vend_on_cancel", dut.u_stock.stock_q[1], 4'd2);
    apply(mk("e_c2", 1, COIN_2, 0, 0, 0, 0, 4'b0, 0, 4'd2, 4'b0, 0, 0, 3'd1));
    apply(mk("e_c1", 1, COIN_1, 0, 0, 0, 0, 4'b0, 0, 4'd3, 4'b0, 0, 0, 3'd1));
    apply(mk("e_disp3", 0, 0, 2'd3, 1, 0, 0, 4'b1000, 0, 4'd0, 4'b0, 0, 0, 3'd2));
    apply(mk("e_coin_in_disp", 1, COIN_5, 0, 0, 0, 0, 4'b1000, 0, 4'd0, 4'b0, 1, 0, 3'd2));
    for (int k = 0; k < 3; k++) apply(idl("e_hold", 4'b1000, 0, 4'd0, 4'b0, 0, 0, 3'd2));
    apply(idl("e_chg", 4'b0, 0, 4'd0, 4'b0, 0, 0, 3'd3));
    apply(idl("e_cmp", 4'b0, 0, 4'd0, 4'b0, 0, 0, 3'd4));
    apply(idl("e_end", 4'b0, 0, 4'd0, 4'b0, 0, 0, 3'd0));

    // Reset in the third DISPENSE cycle aborts everything immediately.
    apply(mk("f_c2", 1, COIN_2, 0, 0, 0, 0, 4'b0, 0, 4'd2, 4'b0, 0, 0, 3'd1));
    apply(mk("f_c1", 1, COIN_1, 0, 0, 0, 0, 4'b0, 0, 4'd3, 4'b0, 0, 0, 3'd1));
    apply(mk("f_disp0", 0, 0, 2'd0, 1, 0, 0, 4'b0001, 0, 4'd0, 4'b0, 0, 0, 3'd2));
    apply(idl("f_hold2", 4'b0001, 0, 4'd0, 4'b0, 0, 0, 3'd2));
    apply(idl("f_hold3", 4'b0001, 0, 4'd0, 4'b0, 0, 0, 3'd2));
    #2 reset_n = 1'b0;
    #1 expect_now("f_reset_abort", 18'b0);
    chk_stock("f_stock0_reinit", dut.u_stock.stock_q[0], 4'd2);
    chk_stock("f_stock3_reinit", dut.u_stock.stock_q[3], 4'd2);
    #2 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) apply(idl("f_post_reset", 4'b0, 0, 4'd0, 4'b0, 0, 0, 3'd0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
